// File: rtl/shifter_pipe.sv
// Two-stage pipelined SLL/SRL/SRA shift unit with valid/ready on both sides.
// Define SHIFTER_PIPE_STATS_EN to add the op_count completed-transfer counter.
module shift_left_logical (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a << shamt;
endmodule

module shift_right_logical (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a >> shamt;
endmodule

module shift_right_arithmetic (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = $unsigned($signed(a) >>> shamt);
endmodule

module shifter_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
`ifdef SHIFTER_PIPE_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
  } s0_t;

  logic        s0_valid;
  s0_t         s0;
  logic        s1_free;
  logic        s0_adv;
  logic        in_fire;
  logic [31:0] sll_y;
  logic [31:0] srl_y;
  logic [31:0] sra_y;
  logic [31:0] result;
  logic        is_sll;
  logic        is_srl;
  logic        is_sra;
  logic        is_pass;

  assign s1_free  = !out_valid || out_ready;
  assign s0_adv   = s0_valid && s1_free;
  assign in_ready = !s0_valid || s1_free;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0       <= '0;
    end else if (in_fire) begin
      s0_valid <= 1'b1;
      s0       <= '{data: in_data, shamt: in_shamt, op: in_op};
    end else if (s0_adv) begin
      s0_valid <= 1'b0;
    end
  end

  shift_left_logical u_sll (
    .a     (s0.data),
    .shamt (s0.shamt),
    .y     (sll_y)
  );

  shift_right_logical u_srl (
    .a     (s0.data),
    .shamt (s0.shamt),
    .y     (srl_y)
  );

  shift_right_arithmetic u_sra (
    .a     (s0.data),
    .shamt (s0.shamt),
    .y     (sra_y)
  );

  assign is_sll  = (s0.op == 2'b00);
  assign is_srl  = (s0.op == 2'b01);
  assign is_sra  = (s0.op == 2'b10);
  assign is_pass = (s0.op == 2'b11);

  always_comb begin
    result = s0.data;
    unique case (1'b1)
      is_sll:  result = sll_y;
      is_srl:  result = srl_y;
      is_sra:  result = sra_y;
      is_pass: result = s0.data;
      default: result = s0.data;
    endcase
  end

  // Illegal op still occupies a slot; it is flagged rather than dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s0_adv) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_err   <= is_pass;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHIFTER_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed-vector bench for shifter_pipe with a negedge scoreboard.
// Stats checks are compiled only with SHIFTER_PIPE_STATS_EN.
module tb_shifter_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
`ifdef SHIFTER_PIPE_STATS_EN
  logic [15:0] op_count;
`endif

  int total;
  int bad;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  op;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  logic [31:0] cur_ed;
  logic        cur_ee;
  logic [32:0] exp_q[$];
  bit          sb_en;

  shifter_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef SHIFTER_PIPE_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_data  = v.d;
    in_shamt = v.sh;
    in_op    = v.op;
    cur_ed   = v.ed;
    cur_ee   = v.ee;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pushes on an upcoming accept, pops and compares on an upcoming drain.
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if (in_valid && in_ready) exp_q.push_back({cur_ee, cur_ed});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          check("sb_data", out_data, exp_q[0][31:0]);
          check("sb_err", {31'd0, out_err}, {31'd0, exp_q[0][32]});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          acc;
    bit          got;
    bit          seen;
    vec_t        bp[3];
    total = 0;
    bad   = 0;
    sb_en = 1'b1;

    vt[0]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0};
    vt[1]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1'b0};
    vt[2]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0};
    vt[3]  = '{32'hFFFF_0000, 5'd0,  2'b10, 32'hFFFF_0000, 1'b0};
    vt[4]  = '{32'hFFFF_0000, 5'd1,  2'b10, 32'hFFFF_8000, 1'b0};
    vt[5]  = '{32'hFFFF_0000, 5'd2,  2'b10, 32'hFFFF_C000, 1'b0};
    vt[6]  = '{32'hFFFF_0000, 5'd3,  2'b10, 32'hFFFF_E000, 1'b0};
    vt[7]  = '{32'hFFFF_0000, 5'd4,  2'b10, 32'hFFFF_F000, 1'b0};
    vt[8]  = '{32'hFFFF_0000, 5'd5,  2'b10, 32'hFFFF_F800, 1'b0};
    vt[9]  = '{32'hFFFF_0000, 5'd6,  2'b10, 32'hFFFF_FC00, 1'b0};
    vt[10] = '{32'hFFFF_0000, 5'd7,  2'b10, 32'hFFFF_FE00, 1'b0};
    vt[11] = '{32'h1234_5678, 5'd9,  2'b11, 32'h1234_5678, 1'b1};
    vt[12] = '{32'h1234_5678, 5'd9,  2'b01, 32'h0009_1A2B, 1'b0};
    vt[13] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0};
    vt[14] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0};
    vt[15] = '{32'hA5A5_A5A5, 5'd0,  2'b00, 32'hA5A5_A5A5, 1'b0};
    vt[16] = '{32'hA5A5_A5A5, 5'd0,  2'b10, 32'hA5A5_A5A5, 1'b0};
    vt[17] = '{32'h0000_ABCD, 5'd16, 2'b00, 32'hABCD_0000, 1'b0};
    vt[18] = '{32'h0000_ABCD, 5'd0,  2'b11, 32'h0000_ABCD, 1'b1};

    bp[0] = '{32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b0};
    bp[1] = '{32'h0000_0003, 5'd8, 2'b00, 32'h0000_0300, 1'b0};
    bp[2] = '{32'hF000_0000, 5'd8, 2'b10, 32'hFFF0_0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    cur_ed    = '0;
    cur_ee    = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SHIFTER_PIPE_STATS_EN
    check("rst_op_count", {16'd0, op_count}, 32'd0);
`endif
    #9 rst_n = 1'b1;
    step();

    // Streaming: full throughput, out_valid appears two edges after accept.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      check("stream_out_valid", {31'd0, out_valid}, (i >= 2) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("tail_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    @(negedge clk);
    check("drained_out_valid", {31'd0, out_valid}, 32'd0);
    check("stream_q_empty", exp_q.size(), 32'd0);
    step();

    // Backpressure: two slots fill, output holds steady.
    out_ready = 1'b0;
    acc  = 0;
    seen = 1'b0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      drive(bp[acc]);
      @(negedge clk);
      got = in_ready;
      if (out_valid) begin
        if (seen) check("bp_hold", out_data, held);
        held = out_data;
        seen = 1'b1;
      end
      step();
      if (got) acc++;
    end
    check("bp_accepted", acc, 32'd2);
    @(negedge clk);
    check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_first_data", out_data, 32'h0000_000F);
    step();
    out_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    check("bp_third_accepted", {31'd0, got}, 32'd1);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("bp_q_empty", exp_q.size(), 32'd0);

    // Reset mid-flight with two requests held inside.
    out_ready = 1'b0;
    drive(vt[0]);
    step();
    drive(vt[1]);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mf_full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mf_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mf_rst_out_data", out_data, 32'd0);
    check("mf_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mf_no_stale", {31'd0, out_valid}, 32'd0);
      step();
    end

`ifdef SHIFTER_PIPE_STATS_EN
    begin
      int done;
      check("st_after_rst", {16'd0, op_count}, 32'd0);
      sb_en = 1'b0;
      done  = 0;
      drive(vt[11]);
      for (int c = 0; c < 70000 && done < 65537; c++) begin
        @(negedge clk);
        if (out_valid && out_ready) done++;
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("st_done", done, 32'd65537);
      @(negedge clk);
      check("st_wrap", {16'd0, op_count}, 32'd1);
      step();
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("st_stall", {16'd0, op_count}, 32'd1);
        step();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) step();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      sb_en = 1'b1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
